// File: rtl/program_counter_rs.sv
// Program counter with a hardware return-address stack for CALL/RET.
// Define PC_INTR_EN to enable interrupt-vector entry on INTR.
module program_counter_rs #(
    parameter int WIDTH     = 10,
    parameter int DEPTH     = 8,
    parameter int RESET_VEC = 1,
    parameter int INTR_VEC  = 'h3FF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [WIDTH-1:0]       DIN,
    input  logic                   PC_LD,
    input  logic                   PC_INC,
    input  logic                   CALL,
    input  logic                   RET,
    input  logic                   INTR,
    output logic [WIDTH-1:0]       PC_COUNT,
    output logic [$clog2(DEPTH):0] STK_CNT,
    output logic                   STK_FULL,
    output logic                   STK_EMPTY,
    output logic                   STK_ERR
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] RVEC = WIDTH'(RESET_VEC);

    logic [WIDTH-1:0] stk [DEPTH];
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] top;
    logic [AW:0]      cnt_nxt;
    logic [AW:0]      cnt_dec;
    logic             err_nxt;
    logic             push;
    logic             full;
    logic             empty;

    assign full    = (STK_CNT == FULL_CNT);
    assign empty   = (STK_CNT == '0);
    assign cnt_dec = STK_CNT - 1'b1;
    assign top     = stk[cnt_dec[AW-1:0]];

`ifdef PC_INTR_EN
    localparam logic [WIDTH-1:0] IVEC = WIDTH'(INTR_VEC);
`else
    logic unused_intr;
    assign unused_intr = INTR;
`endif

    always_comb begin
        pc_nxt    = PC_COUNT;
        cnt_nxt   = STK_CNT;
        err_nxt   = STK_ERR;
        push      = 1'b0;
        push_data = PC_COUNT + 1'b1;
`ifdef PC_INTR_EN
        // Interrupt saves the interrupted PC itself, not PC+1
        if (INTR) begin
            push_data = PC_COUNT;
            pc_nxt    = IVEC;
            if (full) begin
                err_nxt = 1'b1;
            end else begin
                push    = 1'b1;
                cnt_nxt = STK_CNT + 1'b1;
            end
        end else
`endif
        if (RET) begin
            if (empty) begin
                err_nxt = 1'b1;
            end else begin
                pc_nxt  = top;
                cnt_nxt = cnt_dec;
            end
        end else if (CALL) begin
            pc_nxt = DIN;
            if (full) begin
                err_nxt = 1'b1;
            end else begin
                push    = 1'b1;
                cnt_nxt = STK_CNT + 1'b1;
            end
        end else if (PC_LD) begin
            pc_nxt = DIN;
        end else if (PC_INC) begin
            pc_nxt = PC_COUNT + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            PC_COUNT  <= RVEC;
            STK_CNT   <= '0;
            STK_FULL  <= 1'b0;
            STK_EMPTY <= 1'b1;
            STK_ERR   <= 1'b0;
        end else begin
            PC_COUNT  <= pc_nxt;
            STK_CNT   <= cnt_nxt;
            STK_FULL  <= (cnt_nxt == FULL_CNT);
            STK_EMPTY <= (cnt_nxt == '0);
            STK_ERR   <= err_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            stk[STK_CNT[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: tb/tb_program_counter_rs.sv
// Randomised and directed checks of program_counter_rs against a
// queue-based model of the PC and return stack.
module tb_program_counter_rs;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [9:0] DIN = '0;
    logic       PC_LD = 1'b0;
    logic       PC_INC = 1'b0;
    logic       CALL = 1'b0;
    logic       RET = 1'b0;
    logic       INTR = 1'b0;
    logic [9:0] PC_COUNT;
    logic [3:0] STK_CNT;
    logic       STK_FULL;
    logic       STK_EMPTY;
    logic       STK_ERR;

    int passed = 0;
    int total  = 0;

    int m_pc;
    int m_stk[$];
    bit m_err;

`ifdef PC_INTR_EN
    localparam bit INTR_ON = 1'b1;
`else
    localparam bit INTR_ON = 1'b0;
`endif

    program_counter_rs dut (
        .CLK(CLK), .RST(RST), .DIN(DIN),
        .PC_LD(PC_LD), .PC_INC(PC_INC),
        .CALL(CALL), .RET(RET), .INTR(INTR),
        .PC_COUNT(PC_COUNT), .STK_CNT(STK_CNT),
        .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY),
        .STK_ERR(STK_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [16:0] expected();
        int n = m_stk.size();
        return {10'(m_pc), 4'(n), n == 8, n == 0, m_err};
    endfunction

    function automatic logic [16:0] observed();
        return {PC_COUNT, STK_CNT, STK_FULL, STK_EMPTY, STK_ERR};
    endfunction

    // Apply one cycle of inputs and advance the reference model.
    task automatic drive(input bit rst, input bit intr, input bit ret,
                         input bit call, input bit ld, input bit inc,
                         input int din);
        RST = rst; INTR = intr; RET = ret; CALL = call;
        PC_LD = ld; PC_INC = inc; DIN = 10'(din);
        @(posedge CLK);
        #1;
        RST = 0; INTR = 0; RET = 0; CALL = 0; PC_LD = 0; PC_INC = 0;
        if (rst) begin
            m_pc = 1; m_stk.delete(); m_err = 0;
        end else if (INTR_ON && intr) begin
            if (m_stk.size() < 8) m_stk.push_back(m_pc);
            else m_err = 1;
            m_pc = 'h3FF;
        end else if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_err = 1;
        end else if (call) begin
            if (m_stk.size() < 8) m_stk.push_back((m_pc + 1) % 1024);
            else m_err = 1;
            m_pc = din % 1024;
        end else if (ld) begin
            m_pc = din % 1024;
        end else if (inc) begin
            m_pc = (m_pc + 1) % 1024;
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 1, 1, 1, 55);
        total++;
        if (observed() !== 17'({10'd1, 4'd0, 1'b0, 1'b1, 1'b0}))
            $display("FAIL reset: got %h want %h", observed(),
                     {10'd1, 4'd0, 1'b0, 1'b1, 1'b0});
        else passed++;
    endtask

    task automatic test_inc_ld();
        repeat (3) drive(0, 0, 0, 0, 0, 1, 0);
        total++;
        if (PC_COUNT !== 10'd4) $display("FAIL inc3: got %h want 004", PC_COUNT);
        else passed++;
        drive(0, 0, 0, 0, 1, 0, 'h3FF);
        total++;
        if (PC_COUNT !== 10'h3FF) $display("FAIL ld: got %h want 3ff", PC_COUNT);
        else passed++;
        drive(0, 0, 0, 0, 0, 1, 0);
        total++;
        if (PC_COUNT !== 10'h000) $display("FAIL wrap: got %h want 000", PC_COUNT);
        else passed++;
    endtask

    task automatic test_call_ret();
        drive(0, 0, 0, 0, 1, 0, 5);
        drive(0, 0, 0, 1, 0, 0, 20);
        total++;
        if ({PC_COUNT, STK_CNT} !== {10'd20, 4'd1})
            $display("FAIL call1: got pc=%0d cnt=%0d want 20/1", PC_COUNT, STK_CNT);
        else passed++;
        drive(0, 0, 0, 1, 0, 0, 40);
        total++;
        if ({PC_COUNT, STK_CNT} !== {10'd40, 4'd2})
            $display("FAIL call2: got pc=%0d cnt=%0d want 40/2", PC_COUNT, STK_CNT);
        else passed++;
        drive(0, 0, 1, 0, 0, 0, 0);
        total++;
        if (PC_COUNT !== 10'd21) $display("FAIL ret1: got %0d want 21", PC_COUNT);
        else passed++;
        drive(0, 0, 1, 0, 0, 0, 0);
        total++;
        if ({PC_COUNT, STK_EMPTY} !== {10'd6, 1'b1})
            $display("FAIL ret2: got pc=%0d empty=%b want 6/1", PC_COUNT, STK_EMPTY);
        else passed++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0, 0, 100 + i * 3);
        total++;
        if (STK_FULL !== 1'b1) $display("FAIL full: got %b want 1", STK_FULL);
        else passed++;
        drive(0, 0, 0, 1, 0, 0, 99);
        total++;
        if ({PC_COUNT, STK_CNT, STK_ERR} !== {10'd99, 4'd8, 1'b1})
            $display("FAIL ovf: got pc=%0d cnt=%0d err=%b want 99/8/1",
                     PC_COUNT, STK_CNT, STK_ERR);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0);
            total++;
            if (observed() !== expected())
                $display("FAIL lifo%0d: got %h want %h", i, observed(), expected());
            else passed++;
        end
    endtask

    task automatic test_underflow_priority();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 7);
        drive(0, 0, 1, 0, 0, 0, 0);
        total++;
        if ({PC_COUNT, STK_CNT, STK_ERR} !== {10'd7, 4'd0, 1'b1})
            $display("FAIL udf: got pc=%0d cnt=%0d err=%b want 7/0/1",
                     PC_COUNT, STK_CNT, STK_ERR);
        else passed++;
        drive(0, 0, 0, 1, 0, 0, 300);
        drive(0, 0, 1, 1, 1, 1, 500);
        total++;
        if ({PC_COUNT, STK_CNT, STK_ERR} !== {10'd8, 4'd0, 1'b1})
            $display("FAIL prio: got pc=%0d cnt=%0d err=%b want 8/0/1",
                     PC_COUNT, STK_CNT, STK_ERR);
        else passed++;
    endtask

    task automatic test_intr_rst();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 12);
        drive(0, 1, 0, 1, 0, 0, 77);
        total++;
        if (observed() !== expected())
            $display("FAIL intr: got %h want %h", observed(), expected());
        else passed++;
        if (INTR_ON) begin
            drive(0, 0, 1, 0, 0, 0, 0);
            total++;
            if (PC_COUNT !== 10'd12) $display("FAIL intr_top: got %0d want 12", PC_COUNT);
            else passed++;
            drive(0, 1, 0, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 1, 0, 0, 200);
        drive(1, 0, 0, 1, 0, 0, 300);
        total++;
        if ({PC_COUNT, STK_CNT, STK_EMPTY} !== {10'd1, 4'd0, 1'b1})
            $display("FAIL rst_mid: got pc=%0d cnt=%0d want 1/0", PC_COUNT, STK_CNT);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                  ($urandom_range(0, 7) == 0) ? 'h3FF : $urandom_range(0, 1023));
            total++;
            if (observed() !== expected())
                $display("FAIL rand%0d: got %h want %h", i, observed(), expected());
            else passed++;
        end
    endtask

    initial begin
        m_pc = 1; m_err = 0;
        test_reset();
        test_inc_ld();
        test_call_ret();
        test_overflow();
        test_underflow_priority();
        test_intr_rst();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
